blackjack_round_controller: RTL and testbench

Sequencing FSM for one two-player blackjack round: bet entry, initial deal, each player's hit/stand turn, then settlement. Runs the one-hot `state` bus and the money/card registers that feed the combinational result calculator. Latches the calculator's `player1_newmoney`/`player2_newmoney` back into its money registers when the round settles. Sits between the user-input debouncers, the card source, and the result calculator.

---
 rtl/blackjack_round_controller_if.sv | 34 +++
 rtl/blackjack_round_controller.sv | 160 ++++++++++++++++
 tb/tb_blackjack_round_controller.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/blackjack_round_controller_if.sv
// Bus between the blackjack round controller and its neighbours: user input
// pulses, card source handshake, result calculator and status outputs.
interface blackjack_round_controller_if;
  logic       start;
  logic       bet_inc;
  logic       bet_confirm;
  logic       hit;
  logic       stand;
  logic       card_valid;
  logic [3:0] card_rank;
  logic [3:0] player1_newmoney;
  logic [3:0] player2_newmoney;
  logic       card_req;
  logic [7:0] state;
  logic [3:0] player1_money;
  logic [3:0] player2_money;
  logic [3:0] game_money;
  logic [5:0] player1_card;
  logic [5:0] player2_card;

  modport master (
    output start, bet_inc, bet_confirm, hit, stand, card_valid, card_rank,
           player1_newmoney, player2_newmoney,
    input  card_req, state, player1_money, player2_money, game_money,
           player1_card, player2_card
  );

  modport slave (
    input  start, bet_inc, bet_confirm, hit, stand, card_valid, card_rank,
           player1_newmoney, player2_newmoney,
    output card_req, state, player1_money, player2_money, game_money,
           player1_card, player2_card
  );
endinterface

// File: rtl/blackjack_round_controller.sv
// Two-player blackjack round sequencer: bet, deal, turns, settlement.
// Optional feature macro AUTO_STAND_21_EN: a hand sum of exactly 21 ends
// the active player's turn automatically (same latency as a bust).
module blackjack_round_controller #(
  parameter logic [3:0] INIT_MONEY = 4'd7
) (
  input logic                          clk,
  input logic                          rst_n,
  blackjack_round_controller_if.slave  bus
);
  localparam logic [7:0] S_IDLE     = 8'b00000001;
  localparam logic [7:0] S_BET      = 8'b00000010;
  localparam logic [7:0] S_DEAL_P1  = 8'b00000100;
  localparam logic [7:0] S_DEAL_P2  = 8'b00001000;
  localparam logic [7:0] S_P1_TURN  = 8'b00010000;
  localparam logic [7:0] S_P2_TURN  = 8'b00100000;
  localparam logic [7:0] S_GAMEOVER = 8'b01000000;
  localparam logic [7:0] S_RESULT   = 8'b10000000;

`ifdef AUTO_STAND_21_EN
  localparam logic AUTO21 = 1'b1;
`else
  localparam logic AUTO21 = 1'b0;
`endif

  logic [7:0] state, state_nxt;
  logic [3:0] money1, money2, bet;
  logic [3:0] money1_nxt, money2_nxt, bet_nxt;
  logic [5:0] sum1, sum2, sum1_nxt, sum2_nxt;
  logic       card_req, card_req_nxt;
  logic       deal_cnt, deal_cnt_nxt;   // 1 once the first deal card of a player is in

  logic       legal, take, done1, done2, quit_req;
  logic [5:0] pts;
  logic [3:0] min_money;

  // Ranks 0/14/15 are not cards: they never transfer and keep card_req high.
  assign legal     = (bus.card_rank >= 4'd1) && (bus.card_rank <= 4'd13);
  assign take      = card_req && bus.card_valid && legal;
  assign pts       = (bus.card_rank > 4'd10) ? 6'd10 : {2'b00, bus.card_rank};
  assign min_money = (money1 < money2) ? money1 : money2;
  // Turn ends from the registered sum, so it lands one edge after the transfer.
  assign done1     = (sum1 > 6'd21) || (AUTO21 && (sum1 == 6'd21));
  assign done2     = (sum2 > 6'd21) || (AUTO21 && (sum2 == 6'd21));
  // stand is only honoured with no card outstanding
  assign quit_req  = bus.stand && !card_req;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (bus.start) state_nxt = S_BET;
      S_BET:      if (bus.bet_confirm) state_nxt = S_DEAL_P1;
      S_DEAL_P1:  if (take && deal_cnt) state_nxt = S_DEAL_P2;
      S_DEAL_P2:  if (take && deal_cnt) state_nxt = S_P1_TURN;
      S_P1_TURN:  if (done1 || quit_req) state_nxt = S_P2_TURN;
      S_P2_TURN:  if (done2 || quit_req) state_nxt = S_RESULT;
      S_RESULT:   state_nxt = ((bus.player1_newmoney == 4'd0) ||
                               (bus.player2_newmoney == 4'd0)) ? S_GAMEOVER : S_IDLE;
      S_GAMEOVER: if (bus.start) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Datapath next values per phase
  always_comb begin
    money1_nxt   = money1;
    money2_nxt   = money2;
    bet_nxt      = bet;
    sum1_nxt     = sum1;
    sum2_nxt     = sum2;
    card_req_nxt = card_req;
    deal_cnt_nxt = deal_cnt;
    case (state)
      S_IDLE: if (bus.start) begin
        sum1_nxt = 6'd0;
        sum2_nxt = 6'd0;
        bet_nxt  = 4'd1;
      end
      S_BET: begin
        if (bus.bet_inc && (bet < min_money)) bet_nxt = bet + 4'd1;
        if (bus.bet_confirm) begin
          card_req_nxt = 1'b1;
          deal_cnt_nxt = 1'b0;
        end
      end
      // card_req stays high across the P1->P2 deal boundary
      S_DEAL_P1: if (take) begin
        sum1_nxt     = sum1 + pts;
        deal_cnt_nxt = ~deal_cnt;
      end
      S_DEAL_P2: if (take) begin
        sum2_nxt     = sum2 + pts;
        deal_cnt_nxt = ~deal_cnt;
        if (deal_cnt) card_req_nxt = 1'b0;
      end
      S_P1_TURN: begin
        if (take) begin
          sum1_nxt     = sum1 + pts;
          card_req_nxt = 1'b0;
        end else if (bus.hit && !bus.stand && !card_req && !done1) begin
          card_req_nxt = 1'b1;
        end
      end
      S_P2_TURN: begin
        if (take) begin
          sum2_nxt     = sum2 + pts;
          card_req_nxt = 1'b0;
        end else if (bus.hit && !bus.stand && !card_req && !done2) begin
          card_req_nxt = 1'b1;
        end
      end
      S_RESULT: begin
        money1_nxt = bus.player1_newmoney;
        money2_nxt = bus.player2_newmoney;
        bet_nxt    = 4'd0;
      end
      S_GAMEOVER: if (bus.start) begin
        money1_nxt = INIT_MONEY;
        money2_nxt = INIT_MONEY;
      end
      default: card_req_nxt = 1'b0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      money1   <= INIT_MONEY;
      money2   <= INIT_MONEY;
      bet      <= 4'd0;
      sum1     <= 6'd0;
      sum2     <= 6'd0;
      card_req <= 1'b0;
      deal_cnt <= 1'b0;
    end else begin
      money1   <= money1_nxt;
      money2   <= money2_nxt;
      bet      <= bet_nxt;
      sum1     <= sum1_nxt;
      sum2     <= sum2_nxt;
      card_req <= card_req_nxt;
      deal_cnt <= deal_cnt_nxt;
    end
  end

  assign bus.state         = state;
  assign bus.card_req      = card_req;
  assign bus.player1_money = money1;
  assign bus.player2_money = money2;
  assign bus.game_money    = bet;
  assign bus.player1_card  = sum1;
  assign bus.player2_card  = sum2;
endmodule

// File: tb/tb_blackjack_round_controller.sv
// Directed plus randomized bench for blackjack_round_controller with a
// rule-level reference model (money, bet, hand sums) and calculator stand-in.
module tb_blackjack_round_controller;
`ifdef AUTO_STAND_21_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   passes = 0;
  int   fails  = 0;
  int   total  = 0;
  int   m1, m2, bet, s1, s2, n, pts;

  blackjack_round_controller_if bus();

  blackjack_round_controller #(.INIT_MONEY(4'd7)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic p_start();   bus.start = 1;       tick(); bus.start = 0;       endtask
  task automatic p_inc();     bus.bet_inc = 1;     tick(); bus.bet_inc = 0;     endtask
  task automatic p_confirm(); bus.bet_confirm = 1; tick(); bus.bet_confirm = 0; endtask
  task automatic p_hit();     bus.hit = 1;         tick(); bus.hit = 0;         endtask
  task automatic p_stand();   bus.stand = 1;       tick(); bus.stand = 0;       endtask

  // Present one rank for one cycle once a card is being requested.
  task automatic card(input logic [3:0] r);
    for (int i = 0; i < 30 && bus.card_req !== 1'b1; i++) tick();
    chk("card_req_wait", {31'd0, bus.card_req}, 32'd1);
    bus.card_rank  = r;
    bus.card_valid = 1'b1;
    tick();
    bus.card_valid = 1'b0;
  endtask

  function automatic int points(input int r);
    return (r > 10) ? 10 : r;
  endfunction

  function automatic bit turn_over(input int s);
    return (s > 21) || (AUTO && s == 21);
  endfunction

  // Random ranks including junk ones until a real card is accepted.
  task automatic deal_one(output int p);
    int r;
    p = 0;
    for (int k = 0; k < 20; k++) begin
      r = $urandom_range(0, 15);
      if (k == 19) r = $urandom_range(1, 13);
      repeat ($urandom_range(0, 2)) tick();
      card(4'(r));
      if (r >= 1 && r <= 13) begin
        p = points(r);
        break;
      end
    end
  endtask

  // One player's turn driven by a random hit threshold.
  task automatic play(input int p, input int s_in, input logic [7:0] cur,
                      input logic [7:0] nxt, output int s_out);
    int s, thr, q;
    s   = s_in;
    thr = $urandom_range(12, 20);
    for (int g = 0; g < 12; g++) begin
      if (s >= thr) begin
        p_stand();
        chk("turn_stand", {24'd0, bus.state}, {24'd0, nxt});
        break;
      end
      p_hit();
      chk("turn_hit_req", {31'd0, bus.card_req}, 32'd1);
      deal_one(q);
      s += q;
      chk(p == 1 ? "sum1_hit" : "sum2_hit",
          {26'd0, (p == 1 ? bus.player1_card : bus.player2_card)}, s);
      tick();
      if (turn_over(s)) begin
        chk("turn_auto_end", {24'd0, bus.state}, {24'd0, nxt});
        break;
      end
      chk("turn_stay", {24'd0, bus.state}, {24'd0, cur});
    end
    s_out = s;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 0; bus.bet_inc = 0; bus.bet_confirm = 0; bus.hit = 0; bus.stand = 0;
    bus.card_valid = 0; bus.card_rank = 0;
    bus.player1_newmoney = 0; bus.player2_newmoney = 0;
    tick(); tick();
    chk("rst_state", {24'd0, bus.state}, 32'h01);
    chk("rst_money", {24'd0, bus.player1_money, bus.player2_money}, 32'h77);
    chk("rst_bet",   {28'd0, bus.game_money}, 32'd0);
    chk("rst_sums",  {20'd0, bus.player1_card, bus.player2_card}, 32'd0);
    chk("rst_req",   {31'd0, bus.card_req}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Full round, P1 wins a bet of 2
    p_start();
    chk("r1_bet_state", {24'd0, bus.state}, 32'h02);
    chk("r1_bet_init",  {28'd0, bus.game_money}, 32'd1);
    p_inc();
    chk("r1_bet_inc",   {28'd0, bus.game_money}, 32'd2);
    p_confirm();
    chk("r1_deal_state", {24'd0, bus.state}, 32'h04);
    chk("r1_deal_req",   {31'd0, bus.card_req}, 32'd1);
    card(4'd10); card(4'd9);
    chk("r1_p1_sum", {26'd0, bus.player1_card}, 32'd19);
    chk("r1_dealp2", {24'd0, bus.state}, 32'h08);
    card(4'd12); card(4'd5);
    chk("r1_p2_sum", {26'd0, bus.player2_card}, 32'd15);
    chk("r1_p1turn", {24'd0, bus.state}, 32'h10);
    chk("r1_req_off", {31'd0, bus.card_req}, 32'd0);
    p_stand();
    chk("r1_p2turn", {24'd0, bus.state}, 32'h20);
    p_stand();
    chk("r1_result", {24'd0, bus.state}, 32'h80);
    bus.player1_newmoney = 4'd9; bus.player2_newmoney = 4'd5;
    tick();
    chk("r1_money", {24'd0, bus.player1_money, bus.player2_money}, 32'h95);
    chk("r1_idle",  {24'd0, bus.state}, 32'h01);
    chk("r1_bet_clr", {28'd0, bus.game_money}, 32'd0);

    // P1 bust with a discarded rank, then P2 hit+stand together
    p_start(); p_confirm();
    card(4'd10); card(4'd9); card(4'd3); card(4'd4);
    p_hit();
    chk("r2_hit_req", {31'd0, bus.card_req}, 32'd1);
    card(4'd14);
    chk("r2_discard_req", {31'd0, bus.card_req}, 32'd1);
    chk("r2_discard_sum", {26'd0, bus.player1_card}, 32'd19);
    card(4'd5);
    chk("r2_bust_sum",   {26'd0, bus.player1_card}, 32'd24);
    chk("r2_bust_hold",  {24'd0, bus.state}, 32'h10);
    tick();
    chk("r2_bust_adv",   {24'd0, bus.state}, 32'h20);
    p_hit();
    chk("r2_p2_req", {31'd0, bus.card_req}, 32'd1);
    card(4'd3);
    chk("r2_p2_sum", {26'd0, bus.player2_card}, 32'd10);
    bus.hit = 1; bus.stand = 1;
    tick();
    bus.hit = 0; bus.stand = 0;
    chk("r2_hs_state", {24'd0, bus.state}, 32'h80);
    chk("r2_hs_noreq", {31'd0, bus.card_req}, 32'd0);
    bus.player1_newmoney = 4'd7; bus.player2_newmoney = 4'd3;
    tick();
    chk("r2_money", {24'd0, bus.player1_money, bus.player2_money}, 32'h73);

    // Bet limit at min(7,3), then reset in the middle of a P1 hit
    p_start();
    repeat (5) p_inc();
    p_confirm();
    chk("r3_bet_cap", {28'd0, bus.game_money}, 32'd3);
    chk("r3_deal",    {24'd0, bus.state}, 32'h04);
    card(4'd2); card(4'd3); card(4'd4); card(4'd5);
    p_hit();
    chk("r3_pre_rst", {23'd0, bus.state, bus.card_req}, {23'd0, 8'h10, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    chk("r3_rst_state", {24'd0, bus.state}, 32'h01);
    chk("r3_rst_money", {24'd0, bus.player1_money, bus.player2_money}, 32'h77);
    chk("r3_rst_sums",  {20'd0, bus.player1_card, bus.player2_card}, 32'd0);
    chk("r3_rst_req",   {31'd0, bus.card_req}, 32'd0);
    #2 rst_n = 1'b1;
    tick();

    // Game over and restart
    p_start(); p_confirm();
    card(4'd2); card(4'd2); card(4'd2); card(4'd2);
    p_stand(); p_stand();
    bus.player1_newmoney = 4'd0; bus.player2_newmoney = 4'd14;
    tick();
    chk("r4_gameover", {24'd0, bus.state}, 32'h40);
    chk("r4_money", {24'd0, bus.player1_money, bus.player2_money}, 32'h0e);
    p_start();
    chk("r4_restart_state", {24'd0, bus.state}, 32'h01);
    chk("r4_restart_money", {24'd0, bus.player1_money, bus.player2_money}, 32'h77);

    // Sum of exactly 21 in P1's turn
    p_start(); p_confirm();
    card(4'd10); card(4'd1); card(4'd2); card(4'd2);
    p_hit(); card(4'd10);
    chk("r5_sum21", {26'd0, bus.player1_card}, 32'd21);
    tick(); tick();
    chk("r5_21_state", {24'd0, bus.state}, AUTO ? 32'h20 : 32'h10);
    if (!AUTO) p_stand();
    p_stand();
    bus.player1_newmoney = 4'd7; bus.player2_newmoney = 4'd7;
    tick();
    chk("r5_idle", {24'd0, bus.state}, 32'h01);

    // Randomized rounds against the rule-level model
    m1 = 7; m2 = 7;
    for (int r = 0; r < 25; r++) begin
      int v1, v2;
      p_start();
      chk("rnd_bet_state", {24'd0, bus.state}, 32'h02);
      n   = $urandom_range(0, 6);
      bet = 1;
      repeat (n) begin
        p_inc();
        if (bet < ((m1 < m2) ? m1 : m2)) bet++;
      end
      chk("rnd_bet", {28'd0, bus.game_money}, bet);
      p_confirm();
      s1 = 0; s2 = 0;
      deal_one(pts); s1 += pts;
      deal_one(pts); s1 += pts;
      deal_one(pts); s2 += pts;
      deal_one(pts); s2 += pts;
      chk("rnd_deal_sums", {20'd0, bus.player1_card, bus.player2_card}, (s1 << 6) | s2);
      chk("rnd_turn1", {24'd0, bus.state}, 32'h10);
      play(1, s1, 8'h10, 8'h20, s1);
      play(2, s2, 8'h20, 8'h80, s2);
      v1 = (s1 > 21) ? -1 : s1;
      v2 = (s2 > 21) ? -1 : s2;
      if (v1 > v2)      begin m1 += bet; m2 -= bet; end
      else if (v2 > v1) begin m2 += bet; m1 -= bet; end
      bus.player1_newmoney = 4'(m1); bus.player2_newmoney = 4'(m2);
      tick();
      chk("rnd_money", {24'd0, bus.player1_money, bus.player2_money}, (m1 << 4) | m2);
      chk("rnd_after", {24'd0, bus.state}, (m1 == 0 || m2 == 0) ? 32'h40 : 32'h01);
      if (m1 == 0 || m2 == 0) begin
        p_start();
        m1 = 7; m2 = 7;
        chk("rnd_restart", {24'd0, bus.player1_money, bus.player2_money}, 32'h77);
      end
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
